// File: rtl/ysyx_23060286_imm_pkg.sv
// Shared definitions for the IDU immediate stage: type codes and width helpers.
package ysyx_23060286_imm_pkg;

    localparam int IMM_TYPE_W = 3;

    localparam logic [IMM_TYPE_W-1:0] IMM_NONE = 3'b000;
    localparam logic [IMM_TYPE_W-1:0] IMM_U    = 3'b001;
    localparam logic [IMM_TYPE_W-1:0] IMM_J    = 3'b010;
    localparam logic [IMM_TYPE_W-1:0] IMM_B    = 3'b011;
    localparam logic [IMM_TYPE_W-1:0] IMM_I    = 3'b100;
    localparam logic [IMM_TYPE_W-1:0] IMM_S    = 3'b101;
    localparam logic [IMM_TYPE_W-1:0] IMM_Z    = 3'b110;
    localparam logic [IMM_TYPE_W-1:0] IMM_SH   = 3'b111;

    function automatic bit xlenLegal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/ysyx_23060286_imm_ext.sv
// Combinational immediate extractor: picks fields out of a raw instruction and
// extends them to XLEN, flagging unsupported types or illegal encodings.
module ysyx_23060286_imm_ext
    import ysyx_23060286_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]           inst,
    input  logic [IMM_TYPE_W-1:0] immType,
    output logic [XLEN-1:0]       imm,
    output logic                  err
);

    // Sign-extended types start from a sign-filled word and overwrite the low field.
    always_comb begin
        imm = '0;
        err = 1'b0;
        unique case (immType)
            IMM_I: begin
                imm = {XLEN{inst[31]}};
                imm[11:0] = inst[31:20];
            end
            IMM_S: begin
                imm = {XLEN{inst[31]}};
                imm[11:0] = {inst[31:25], inst[11:7]};
            end
            IMM_B: begin
                imm = {XLEN{inst[31]}};
                imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            IMM_U: begin
                imm = {XLEN{inst[31]}};
                imm[31:0] = {inst[31:12], 12'b0};
            end
            IMM_J: begin
                imm = {XLEN{inst[31]}};
                imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            IMM_Z: imm[4:0] = inst[19:15];
            IMM_SH: begin
                if (XLEN == 64) begin
                    imm[5:0] = inst[25:20];
                end else begin
                    // shamt[5] is reserved on RV32; still report the low 5 bits
                    imm[4:0] = inst[24:20];
                    err = inst[25];
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_23060286_imm_stage.sv
// Registered immediate stage with a 2-entry skid buffer (main M + skid K) and flush.
module ysyx_23060286_imm_stage
    import ysyx_23060286_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [IMM_TYPE_W-1:0] in_immtype,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_imm,
    output logic [IMM_TYPE_W-1:0] out_immtype,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_err
);

    if (!xlenLegal(XLEN)) begin : gBadXlen
        $error("ysyx_23060286_imm_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]       imm;
        logic [IMM_TYPE_W-1:0] immType;
        logic [TAG_W-1:0]      tag;
        logic                  err;
    } entry_t;

    entry_t inEnt, mEnt, kEnt;
    logic   mValid, kValid;
    logic   accept, outFire;

    ysyx_23060286_imm_ext #(.XLEN(XLEN)) uExt (
        .inst    (in_inst),
        .immType (in_immtype),
        .imm     (inEnt.imm),
        .err     (inEnt.err)
    );

    assign inEnt.immType = in_immtype;
    assign inEnt.tag     = in_tag;

    assign in_ready = !kValid;
    assign accept   = in_valid && in_ready && !flush;
    assign outFire  = mValid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            mValid <= 1'b0;
            kValid <= 1'b0;
            mEnt   <= '0;
            kEnt   <= '0;
        end else if (flush) begin
            mValid <= 1'b0;
            kValid <= 1'b0;
        end else if (!mValid || outFire) begin
            // K is older than anything upstream, so it refills M first
            if (kValid) begin
                mEnt   <= kEnt;
                mValid <= 1'b1;
                kValid <= 1'b0;
            end else if (accept) begin
                mEnt   <= inEnt;
                mValid <= 1'b1;
            end else begin
                mValid <= 1'b0;
            end
        end else if (accept) begin
            kEnt   <= inEnt;
            kValid <= 1'b1;
        end
    end

    assign out_valid   = mValid;
    assign out_imm     = mEnt.imm;
    assign out_immtype = mEnt.immType;
    assign out_tag     = mEnt.tag;
    assign out_err     = mEnt.err;

endmodule

// File: tb/tb_ysyx_23060286_imm_stage.sv
// Bench for the immediate stage: XLEN=32 and XLEN=64 instances share stimulus,
// a queue holds expected entries, directed steps cover handshake corner cases.
module tb_ysyx_23060286_imm_stage;

    logic        clk = 1'b0;
    logic        rst, flush, inValid, outReady;
    logic [31:0] inInst, inTag;
    logic [2:0]  inType;

    logic        rdy32, v32, err32, rdy64, v64, err64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [2:0]  typ32, typ64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] imm32, imm64;
        logic [2:0]  t;
        logic [31:0] tag;
        logic        err32, err64;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ysyx_23060286_imm_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(rdy32), .in_inst(inInst), .in_immtype(inType), .in_tag(inTag),
        .out_valid(v32), .out_ready(outReady), .out_imm(imm32), .out_immtype(typ32),
        .out_tag(tag32), .out_err(err32)
    );

    ysyx_23060286_imm_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(rdy64), .in_inst(inInst), .in_immtype(inType), .in_tag(inTag),
        .out_valid(v64), .out_ready(outReady), .out_imm(imm64), .out_immtype(typ64),
        .out_tag(tag64), .out_err(err64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference extraction written as signed-field arithmetic.
    function automatic void model(input logic [31:0] i, input logic [2:0] t, input int xlen,
                                  output logic [63:0] imm, output logic err);
        logic signed [63:0] v;
        err = 1'b0;
        case (t)
            3'b100:  v = $signed(i[31:20]);
            3'b101:  v = $signed({i[31:25], i[11:7]});
            3'b011:  v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            3'b001:  v = $signed({i[31:12], 12'h000});
            3'b010:  v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            3'b110:  v = 64'(i[19:15]);
            3'b111: begin
                if (xlen == 64) v = 64'(i[25:20]);
                else begin
                    v = 64'(i[24:20]);
                    err = i[25];
                end
            end
            default: begin
                v = 0;
                err = 1'b1;
            end
        endcase
        imm = (xlen == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
    endfunction

    // One clock: sample at negedge, pop on output fire, push on accept.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
        end else begin
            if (v32 && outReady) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'(v32), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_imm32", 64'(imm32), e.imm32);
                    chk("sb_imm64", imm64, e.imm64);
                    chk("sb_type", 64'(typ32), 64'(e.t));
                    chk("sb_tag", 64'(tag32), 64'(e.tag));
                    chk("sb_err32", 64'(err32), 64'(e.err32));
                    chk("sb_err64", 64'(err64), 64'(e.err64));
                    chk("sb_v64", 64'(v64), 64'd1);
                end
            end
            if (flush) begin
                sb.delete();
            end else if (inValid && rdy32) begin
                model(inInst, inType, 32, e.imm32, e.err32);
                model(inInst, inType, 64, e.imm64, e.err64);
                e.t   = inType;
                e.tag = inTag;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [2:0] t, input logic [31:0] tg);
        inValid = 1'b1;
        inInst  = i;
        inType  = t;
        inTag   = tg;
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_valid"}, 64'(v32), 64'd0);
        chk({tag, "_ready"}, 64'(rdy32), 64'd1);
        chk({tag, "_valid64"}, 64'(v64), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        inInst = 32'h0; inType = 3'b0; inTag = 32'h0;
        cyc(); cyc();
        chkIdle("reset");
        chk("reset_imm", 64'(imm32), 64'd0);
        chk("reset_tag", 64'(tag32), 64'd0);
        chk("reset_type", 64'(typ32), 64'd0);
        chk("reset_err", 64'(err32), 64'd0);
        rst = 1'b0;
        cyc();

        // I-type, one-cycle latency
        drive(32'hFFF0_0093, 3'b100, 32'h8000_0000);
        cyc();
        inValid = 1'b0;
        chk("i_valid", 64'(v32), 64'd1);
        chk("i_imm", 64'(imm32), 64'hFFFF_FFFF);
        chk("i_tag", 64'(tag32), 64'h8000_0000);
        chk("i_err", 64'(err32), 64'd0);
        cyc();

        drive(32'hFE20_AE23, 3'b101, 32'h100);
        cyc();
        inValid = 1'b0;
        chk("s_imm", 64'(imm32), 64'hFFFF_FFFC);
        cyc();

        drive(32'h8000_00B7, 3'b001, 32'h104);
        cyc();
        inValid = 1'b0;
        chk("u_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("u_imm32", 64'(imm32), 64'h8000_0000);
        cyc();

        drive(32'h000F_8000, 3'b110, 32'h108);
        cyc();
        chk("z_imm", 64'(imm32), 64'h1F);
        drive(32'h0200_0013, 3'b111, 32'h10C);
        cyc();
        chk("sh_err32", 64'(err32), 64'd1);
        chk("sh_err64", 64'(err64), 64'd0);
        chk("sh_imm64", imm64, 64'h20);
        drive(32'hFFFF_FFFF, 3'b000, 32'h110);
        cyc();
        inValid = 1'b0;
        chk("none_imm", 64'(imm32), 64'd0);
        chk("none_err", 64'(err32), 64'd1);
        cyc();

        // Back-to-back random traffic at full throughput
        for (int n = 0; n < 24; n++) begin
            drive($urandom, 3'($urandom_range(0, 7)), 32'h2000 + 32'(n));
            chk("thru_ready", 64'(rdy32), 64'd1);
            cyc();
        end
        inValid = 1'b0;
        cyc();
        chk("thru_drain", 64'(sb.size()), 64'd0);

        // Backpressure: A to M, B to K, C held upstream
        outReady = 1'b0;
        drive(32'h0010_0093, 3'b100, 32'hA);
        cyc();
        drive(32'h0020_0093, 3'b100, 32'hB);
        cyc();
        chk("bp_ready_low", 64'(rdy32), 64'd0);
        drive(32'h0030_0093, 3'b100, 32'hC);
        cyc();
        chk("bp_hold_ready", 64'(rdy32), 64'd0);
        chk("bp_hold_tag", 64'(tag32), 64'hA);
        chk("bp_hold_imm", 64'(imm32), 64'h1);
        outReady = 1'b1;
        cyc();
        chk("bp_ready_back", 64'(rdy32), 64'd1);
        chk("bp_b_tag", 64'(tag32), 64'hB);
        cyc();
        inValid = 1'b0;
        chk("bp_c_tag", 64'(tag32), 64'hC);
        cyc();
        chk("bp_empty", 64'(v32), 64'd0);
        chk("bp_drain", 64'(sb.size()), 64'd0);

        // Flush with M and K full and a same-cycle input
        outReady = 1'b0;
        drive(32'h0040_0093, 3'b100, 32'hF0);
        cyc();
        drive(32'h0050_0093, 3'b100, 32'hF1);
        cyc();
        drive(32'h0060_0093, 3'b100, 32'hF2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        inValid = 1'b0;
        chkIdle("flush");
        outReady = 1'b1;
        cyc(); cyc(); cyc();
        chk("flush_quiet", 64'(v32), 64'd0);

        // Reset while K is full
        outReady = 1'b0;
        drive(32'h0070_0093, 3'b100, 32'hE0);
        cyc();
        drive(32'h0080_0093, 3'b100, 32'hE1);
        cyc();
        inValid = 1'b0;
        chk("prerst_ready", 64'(rdy32), 64'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chkIdle("midrst");
        chk("midrst_imm", 64'(imm32), 64'd0);
        chk("midrst_tag", 64'(tag32), 64'd0);
        chk("midrst_type", 64'(typ32), 64'd0);
        chk("midrst_err", 64'(err32), 64'd0);
        chk("midrst_imm64", imm64, 64'd0);
        outReady = 1'b1;
        cyc();
        chk("end_queue", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060286_imm_stage.md
Name: ysyx_23060286_imm_stage

Overview:
Registered immediate-generation stage for the IDU. It accepts a raw instruction, an immediate-type code and a sideband tag over a valid/ready handshake, and produces the sign- or zero-extended XLEN immediate one cycle later. The stage is generalised to XLEN 32/64 and adds two types: CSR zimm and shift amount. A 2-entry skid buffer keeps full throughput under backpressure, and a flush input discards in-flight entries.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag (typically PC) carried alongside each entry.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
flush  input  1  discard all held entries; drop input this cycle
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry
in_inst  input  32  raw instruction
in_immtype  input  3  immediate type code
in_tag  input  TAG_W  sideband data, passed through unchanged
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  extended immediate
out_immtype  output  3  type code of the output entry
out_tag  output  TAG_W  tag of the output entry
out_err  output  1  type code unsupported or encoding illegal

Behaviour:
- Type codes (unchanged from the current 32-bit generator):
  - 100 I: sext(inst[31:20]).
  - 101 S: sext({inst[31:25],inst[11:7]}).
  - 011 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - 001 U: sext({inst[31:12],12'b0}) to XLEN.
  - 010 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - New 110 Z: zext(inst[19:15]).
  - New 111 SH: XLEN=64 gives zext(inst[25:20]); XLEN=32 gives zext(inst[24:20]).
  - 000: imm=0, err=1.
- err=1 also for SH when XLEN=32 and inst[25]=1; imm is still computed as above.
- All extension is to XLEN. U with XLEN=64 sign-extends from bit 31.
- Storage: main register (M) drives the outputs; skid register (K) holds overflow.
- Latency: 1 cycle from in_valid&in_ready to out_valid when M is empty or draining.
- in_ready = !K_valid. It is registered and does not combinationally depend on out_ready.
- Accept = in_valid & in_ready & !flush.
- Output fire = out_valid & out_ready.
- Per-cycle update when flush=0:
  - M empty or firing, K empty: M <= input if accepted, else M_valid <= 0.
  - M empty or firing, K full: M <= K, K_valid <= 0. No accept is possible because in_ready=0.
  - M full and not firing: accepted input goes to K; M holds.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- flush=1: M_valid <= 0 and K_valid <= 0 next cycle; the same-cycle input is dropped; a same-cycle output fire still counts as consumed. Flush has priority over all other updates.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_immtype=0, out_tag=0, out_err=0; K cleared. Reset mid-transfer discards all entries.
- out_imm, out_immtype, out_tag and out_err are stable while out_valid=1 and out_ready=0.
- Throughput: 1 entry/cycle with out_ready held high.

Decomposition:
- Shared package ysyx_23060286_imm_pkg holds:
  - type-code constants IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH, IMM_NONE;
  - the 3-bit type width;
  - the XLEN legality check.
- Sub-module ysyx_23060286_imm_ext: purely combinational extractor (inst, immtype, XLEN parameter) producing imm and err. The stage instantiates it once, on the input side, so the registered value is stored.

Test Plan:
- XLEN=32: in 0xFFF00093 type 100 tag 0x80000000, out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, tag=0x80000000, err=0.
- XLEN=32: in 0xFE20AE23 type 101 -> imm=0xFFFFFFFC. XLEN=64: in 0x800000B7 type 001 -> imm=0xFFFFFFFF80000000.
- Backpressure:
  - With out_ready=0, present entries A, B, C on consecutive cycles.
  - A lands in M and B in K; in_ready=0 from the cycle after B is accepted, so C is held upstream.
  - Raise out_ready: outputs A, B, C in order on consecutive cycles, and in_ready returns to 1.
- flush with M and K full and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the dropped input never appears at the output.
- Type 110 with inst[19:15]=31 -> imm=0x1F. XLEN=32 type 111 with inst[25]=1 -> err=1. Type 000 -> imm=0, err=1.
- rst asserted while K is full -> next cycle out_valid=0, in_ready=1, all data outputs 0.
